hash_result_streamer: RTL and testbench
=======================================

Name: hash_result_streamer

Overview:
- Sits directly downstream of the Hirose-PRESENT hash wrapper, inside the hardware autotest path.
- Times one hash run from the moment the test sequencer releases the UUT from reset until the UUT asserts its end signal.
- Captures the 128-bit digest and the cycle count.
- Serialises both, plus a status byte, as a byte stream with a valid/ready handshake. The SD sector writer consumes this stream.

Parameters:
- HASH_WIDTH, 128, digest width in bits (multiple of 8).
- CNT_WIDTH, 32, cycle counter width in bits (multiple of 8).
- TIMEOUT, 1048576, max RUN cycles before the run is declared failed (>=2, < 2^CNT_WIDTH).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle pulse: UUT has just been released from reset; begin timing.
- end_i  in  1  UUT end_signal (level).
- hash_i  in  HASH_WIDTH  UUT hash_output; valid while end_i=1.
- byte_o  out  8  stream data.
- byte_valid_o  out  1  byte_o valid.
- byte_ready_i  in  1  consumer accepts byte_o.
- busy_o  out  1  high in RUN or SEND.
- done_o  out  1  one-cycle pulse after the last byte is accepted.
- timeout_o  out  1  sticky flag for the last completed run: 1 = timed out.
- cycles_o  out  CNT_WIDTH  latched cycle count of the last run.

Behaviour:
- Reset (rst=0, async): state=IDLE; byte_o=0; byte_valid_o=0; busy_o=0; done_o=0; timeout_o=0; cycles_o=0; internal counter and byte index =0.
- Record format, RECORD_BYTES = HASH_WIDTH/8 + CNT_WIDTH/8 + 1 (21 by default):
  - digest bytes, MSB first;
  - then count bytes, MSB first;
  - then status byte: 0xA5 = ok, 0xE1 = timeout.
- FSM states: IDLE, RUN, SEND, DONE.
- IDLE:
  - start_i=1 -> RUN; counter<=0; timeout_o<=0.
  - end_i is ignored in IDLE.
- RUN:
  - Each cycle: if end_i=1, latch hash_i, latch cycles_o<=counter, status=ok, index<=0, go to SEND.
  - Otherwise, if counter==TIMEOUT-1: latch digest=0, cycles_o<=TIMEOUT, timeout_o<=1, status=timeout, go to SEND.
  - Otherwise counter++.
  - Count semantics: end_i already high on the first RUN cycle gives count 0. end_i first high on the Nth RUN cycle (1-based) gives count N-1.
  - end_i and timeout in the same cycle: end_i wins (ok record).
- SEND:
  - byte_valid_o=1 and byte_o=record[index]; both register-driven, first valid the cycle after entering SEND.
  - On byte_valid_o & byte_ready_i: index++ and the next byte is presented the following cycle.
  - byte_o is held stable while valid & !ready.
  - When index==RECORD_BYTES-1 is accepted: byte_valid_o<=0, go to DONE.
  - byte_ready_i high while valid=0 is ignored.
- DONE: done_o=1 for exactly one cycle -> IDLE.
- busy_o is 1 in RUN and SEND.
- start_i outside IDLE is ignored; no restart mid-run and no record truncation.
- Reset mid-operation (RUN or SEND): immediate return to reset values; the partial record is discarded and is not resumed.
- Latched digest and count are unaffected by hash_i/end_i changes after capture.

Test Plan:
- Nominal run:
  - Stimulus: start_i pulse; end_i rises on the 33rd RUN cycle with hash_i=0x0123456789ABCDEF_FEDCBA9876543210; byte_ready_i tied 1.
  - Required: cycles_o=32; 21 consecutive bytes 01 23 .. 10, then 00 00 00 20, then A5; done_o pulses once; timeout_o=0.
- Backpressure:
  - Stimulus: same record; byte_ready_i toggles 1,0,0,1...
  - Required: each byte held stable while not ready; no byte duplicated or dropped; exactly 21 handshakes before done_o.
- Timeout:
  - Stimulus: TIMEOUT=64; end_i never rises.
  - Required: SEND entered after 64 RUN cycles; 16 bytes 00, then 00 00 00 40, then E1; timeout_o=1 after the run.
- Boundary:
  - Stimulus: end_i=1 already on the first RUN cycle.
  - Required: count bytes 00 00 00 00, status A5.
  - Stimulus: TIMEOUT=64 with end_i rising on the 64th RUN cycle.
  - Required: ok record, count 63.
- Ignored start / reset mid-stream:
  - Stimulus: start_i pulse during SEND.
  - Required: no effect.
  - Stimulus: rst low after 5 bytes accepted.
  - Required: all outputs return to reset values asynchronously. A new start_i then produces a full fresh 21-byte record.

Source files
------------

// File: rtl/hash_result_streamer.sv
// rtl/hash_result_streamer.sv - times one hash run, captures digest and cycle count, streams them as a byte record
// Record layout: digest MSB first, cycle count MSB first, then status byte (0xA5 ok / 0xE1 timeout).
module hash_result_streamer #(
  parameter int HASH_WIDTH = 128,
  parameter int CNT_WIDTH  = 32,
  parameter int TIMEOUT    = 1048576
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  end_i,
  input  logic [HASH_WIDTH-1:0] hash_i,
  output logic [7:0]            byte_o,
  output logic                  byte_valid_o,
  input  logic                  byte_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  timeout_o,
  output logic [CNT_WIDTH-1:0]  cycles_o
);

  localparam int RECORD_BYTES = HASH_WIDTH / 8 + CNT_WIDTH / 8 + 1;
  localparam int REC_W        = RECORD_BYTES * 8;
  localparam int IDX_W        = $clog2(RECORD_BYTES);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST    = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_TIMEOUT = CNT_WIDTH'(TIMEOUT);
  localparam logic [IDX_W-1:0]     IDX_LAST    = IDX_W'(RECORD_BYTES - 1);
  localparam logic [7:0]           STATUS_OK   = 8'hA5;
  localparam logic [7:0]           STATUS_TO   = 8'hE1;

  typedef enum logic [1:0] {IDLE, RUN, SEND, DONE} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] counter;
  logic [IDX_W-1:0]     index;
  logic [REC_W-1:0]     rec_q;
  logic [REC_W-1:0]     rec_load;

  // end_i takes priority over a simultaneous timeout, so the ok record is built whenever end_i is high
  always_comb begin
    rec_load = '0;
    if (end_i) begin
      rec_load = {hash_i, counter, STATUS_OK};
    end else begin
      rec_load = {{HASH_WIDTH{1'b0}}, CNT_TIMEOUT, STATUS_TO};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      counter      <= '0;
      index        <= '0;
      rec_q        <= '0;
      byte_o       <= 8'h00;
      byte_valid_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      timeout_o    <= 1'b0;
      cycles_o     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            state     <= RUN;
            counter   <= '0;
            timeout_o <= 1'b0;
            busy_o    <= 1'b1;
          end
        end

        RUN: begin
          if (end_i || counter == CNT_LAST) begin
            // rec_q keeps only the bytes still to be presented; the first one goes straight to byte_o
            state        <= SEND;
            index        <= '0;
            cycles_o     <= end_i ? counter : CNT_TIMEOUT;
            timeout_o    <= !end_i;
            byte_o       <= rec_load[REC_W-1 -: 8];
            byte_valid_o <= 1'b1;
            rec_q        <= {rec_load[REC_W-9:0], 8'h00};
          end else begin
            counter <= counter + 1'b1;
          end
        end

        SEND: begin
          if (byte_valid_o && byte_ready_i) begin
            if (index == IDX_LAST) begin
              state        <= DONE;
              byte_valid_o <= 1'b0;
              byte_o       <= 8'h00;
              busy_o       <= 1'b0;
              done_o       <= 1'b1;
            end else begin
              index  <= index + 1'b1;
              byte_o <= rec_q[REC_W-1 -: 8];
              rec_q  <= {rec_q[REC_W-9:0], 8'h00};
            end
          end
        end

        DONE: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hash_result_streamer.sv
// tb/tb_hash_result_streamer.sv - directed self-checking bench for hash_result_streamer
module tb_hash_result_streamer;

  localparam int TO = 64;
  localparam logic [127:0] H_A = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] H_B = 128'h00112233445566778899AABBCCDDEEFF;

  logic         clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic         end_i;
  logic [127:0] hash_i;
  logic [7:0]   byte_o;
  logic         byte_valid_o;
  logic         byte_ready_i;
  logic         busy_o;
  logic         done_o;
  logic         timeout_o;
  logic [31:0]  cycles_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] got [0:31];
  int nacc;

  always #5 clk = ~clk;

  hash_result_streamer #(
    .HASH_WIDTH(128),
    .CNT_WIDTH (32),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .end_i       (end_i),
    .hash_i      (hash_i),
    .byte_o      (byte_o),
    .byte_valid_o(byte_valid_o),
    .byte_ready_i(byte_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .timeout_o   (timeout_o),
    .cycles_o    (cycles_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " byte_o"}, 192'(byte_o), 192'(0));
    chk({tag, " valid"}, 192'(byte_valid_o), 192'(0));
    chk({tag, " busy"}, 192'(busy_o), 192'(0));
    chk({tag, " done"}, 192'(done_o), 192'(0));
    chk({tag, " timeout"}, 192'(timeout_o), 192'(0));
    chk({tag, " cycles"}, 192'(cycles_o), 192'(0));
  endtask

  // Drains one record; bp selects the 1,0,0,1 ready pattern, start_at pulses start_i mid-stream,
  // abort_after>0 stops right after that many handshakes have completed.
  task automatic collect(input bit bp, input int start_at, input int abort_after);
    bit pv = 1'b0;
    bit pr = 1'b0;
    logic [7:0] pb = 8'h00;
    logic [3:0] pat = 4'b1001;
    int k = 0;
    bit seen_done = 1'b0;
    nacc = 0;
    for (int i = 0; i < 32; i++) got[i] = 8'h00;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (pv && !pr) begin
        chk("hold valid", 192'(byte_valid_o), 192'(1));
        chk("hold data", 192'(byte_o), 192'(pb));
      end
      if (done_o) begin
        seen_done = 1'b1;
        break;
      end
      start_i = (cyc == start_at);
      byte_ready_i = byte_valid_o ? (bp ? pat[k % 4] : 1'b1) : 1'b1;
      if (byte_valid_o) k++;
      if (byte_valid_o && byte_ready_i && nacc < 32) begin
        got[nacc] = byte_o;
        nacc++;
      end
      pv = byte_valid_o;
      pr = byte_ready_i;
      pb = byte_o;
      step();
      if (abort_after > 0 && nacc == abort_after) break;
    end
    start_i = 1'b0;
    byte_ready_i = 1'b1;
    if (abort_after == 0) begin
      chk("done seen", 192'(seen_done), 192'(1));
      step();
      chk("done one cycle", 192'(done_o), 192'(0));
    end
  endtask

  task automatic check_rec(input string tag, input logic [167:0] exp);
    chk({tag, " nbytes"}, 192'(nacc), 192'(21));
    for (int i = 0; i < 21; i++)
      chk($sformatf("%s byte%0d", tag, i), 192'(got[i]), 192'(exp[167 - 8 * i -: 8]));
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    start_i = 1'b0;
    end_i = 1'b0;
    hash_i = '0;
    byte_ready_i = 1'b1;
    #1 rst = 1'b0;
    #2 chk_reset_vals("reset");
    steps(2);
    rst = 1'b1;
    step();

    // nominal: end_i on the 33rd RUN cycle
    hash_i = H_A;
    pulse_start();
    steps(32);
    chk("nom busy in run", 192'(busy_o), 192'(1));
    chk("nom idle valid", 192'(byte_valid_o), 192'(0));
    end_i = 1'b1;
    step();
    end_i = 1'b0;
    hash_i = '1;
    collect(1'b0, -1, 0);
    check_rec("nom", {H_A, 32'd32, 8'hA5});
    chk("nom cycles", 192'(cycles_o), 192'(32));
    chk("nom timeout", 192'(timeout_o), 192'(0));

    // backpressure with an ignored start pulse during SEND
    hash_i = H_A;
    pulse_start();
    steps(32);
    end_i = 1'b1;
    step();
    end_i = 1'b0;
    collect(1'b1, 10, 0);
    check_rec("bp", {H_A, 32'd32, 8'hA5});
    steps(3);
    chk("bp start ignored busy", 192'(busy_o), 192'(0));
    chk("bp start ignored valid", 192'(byte_valid_o), 192'(0));

    // timeout: end_i never rises
    hash_i = H_B;
    pulse_start();
    steps(63);
    chk("to valid before", 192'(byte_valid_o), 192'(0));
    chk("to busy", 192'(busy_o), 192'(1));
    step();
    chk("to valid after 64", 192'(byte_valid_o), 192'(1));
    collect(1'b0, -1, 0);
    check_rec("to", {128'h0, 32'd64, 8'hE1});
    chk("to timeout flag", 192'(timeout_o), 192'(1));
    chk("to cycles", 192'(cycles_o), 192'(64));

    // boundary: end_i already high on the first RUN cycle (and while IDLE)
    hash_i = H_B;
    end_i = 1'b1;
    pulse_start();
    step();
    end_i = 1'b0;
    collect(1'b0, -1, 0);
    check_rec("b0", {H_B, 32'd0, 8'hA5});
    chk("b0 timeout cleared", 192'(timeout_o), 192'(0));

    // boundary: end_i and the timeout cycle coincide
    hash_i = H_A;
    pulse_start();
    steps(63);
    end_i = 1'b1;
    step();
    end_i = 1'b0;
    collect(1'b0, -1, 0);
    check_rec("b63", {H_A, 32'd63, 8'hA5});
    chk("b63 timeout", 192'(timeout_o), 192'(0));

    // reset after 5 accepted bytes, then a fresh record
    hash_i = H_A;
    pulse_start();
    steps(32);
    end_i = 1'b1;
    step();
    end_i = 1'b0;
    collect(1'b0, -1, 5);
    chk("mid nacc", 192'(nacc), 192'(5));
    #2 rst = 1'b0;
    #1 chk_reset_vals("midreset");
    step();
    rst = 1'b1;
    step();
    hash_i = H_B;
    pulse_start();
    steps(10);
    end_i = 1'b1;
    step();
    end_i = 1'b0;
    collect(1'b0, -1, 0);
    check_rec("fresh", {H_B, 32'd10, 8'hA5});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
